gomoku_board_store: RTL and testbench

//  Board memory that serves the game controller's write strobes. Holds the 15x15 board as separate

---
 rtl/gomoku_board_store.sv | 128 ++++++++++++
 tb/tb_gomoku_board_store.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gomoku_board_store.sv
// Gomoku board memory: black/white occupancy planes written on clk_slow, with
// combinational 9-cell line windows around a centre and a cursor-row occupancy view.
module gomoku_board_store #(
    parameter int BOARD_SIZE = 15,
    parameter int HALF_SPAN  = 4
) (
    input  logic                    clk_slow,
    input  logic                    rst,
    input  logic                    data_clr,
    input  logic                    data_write,
    input  logic [3:0]              cursor_y,
    input  logic [3:0]              cursor_x,
    input  logic                    crt_player,
    input  logic [3:0]              consider_y,
    input  logic [3:0]              consider_x,
    output logic [2*HALF_SPAN:0]    black_y,
    output logic [2*HALF_SPAN:0]    black_x,
    output logic [2*HALF_SPAN:0]    black_yx,
    output logic [2*HALF_SPAN:0]    black_xy,
    output logic [2*HALF_SPAN:0]    white_y,
    output logic [2*HALF_SPAN:0]    white_x,
    output logic [2*HALF_SPAN:0]    white_yx,
    output logic [2*HALF_SPAN:0]    white_xy,
    output logic [BOARD_SIZE-1:0]   chess_row,
    output logic [7:0]              move_count,
    output logic [3:0]              last_y,
    output logic [3:0]              last_x,
    output logic                    write_ack,
    output logic                    write_reject,
    output logic                    board_full
);

    localparam int         WIN_WIDTH  = 2 * HALF_SPAN + 1;
    localparam logic [7:0] CELL_COUNT = 8'(BOARD_SIZE * BOARD_SIZE);
    localparam logic [3:0] NO_COORD   = 4'hF;

    logic [BOARD_SIZE-1:0][BOARD_SIZE-1:0] black_plane;
    logic [BOARD_SIZE-1:0][BOARD_SIZE-1:0] white_plane;
    logic                                  cursor_in_range;
    logic                                  cursor_occupied;

    // Off-board coordinates (negative or past the edge) always read as empty.
    function automatic logic cell_at(
        input logic [BOARD_SIZE-1:0][BOARD_SIZE-1:0] plane,
        input int                                    row,
        input int                                    col
    );
        if (row < 0 || row >= BOARD_SIZE || col < 0 || col >= BOARD_SIZE)
            return 1'b0;
        return plane[row[3:0]][col[3:0]];
    endfunction

    always_comb begin
        cursor_in_range = (cursor_y < 4'(BOARD_SIZE)) && (cursor_x < 4'(BOARD_SIZE));
        cursor_occupied = 1'b0;
        chess_row       = '0;
        if (cursor_in_range)
            cursor_occupied = black_plane[cursor_y][cursor_x] | white_plane[cursor_y][cursor_x];
        if (cursor_y < 4'(BOARD_SIZE))
            chess_row = black_plane[cursor_y] | white_plane[cursor_y];
    end

    // Window bit i sits at offset i-HALF_SPAN from the centre along each line direction.
    always_comb begin
        black_y  = '0;
        black_x  = '0;
        black_yx = '0;
        black_xy = '0;
        white_y  = '0;
        white_x  = '0;
        white_yx = '0;
        white_xy = '0;
        for (int i = 0; i < WIN_WIDTH; i++) begin
            black_y[i]  = cell_at(black_plane, int'(consider_y) + i - HALF_SPAN, int'(consider_x));
            black_x[i]  = cell_at(black_plane, int'(consider_y), int'(consider_x) + i - HALF_SPAN);
            black_yx[i] = cell_at(black_plane, int'(consider_y) + i - HALF_SPAN,
                                  int'(consider_x) + i - HALF_SPAN);
            black_xy[i] = cell_at(black_plane, int'(consider_y) + i - HALF_SPAN,
                                  int'(consider_x) - i + HALF_SPAN);
            white_y[i]  = cell_at(white_plane, int'(consider_y) + i - HALF_SPAN, int'(consider_x));
            white_x[i]  = cell_at(white_plane, int'(consider_y), int'(consider_x) + i - HALF_SPAN);
            white_yx[i] = cell_at(white_plane, int'(consider_y) + i - HALF_SPAN,
                                  int'(consider_x) + i - HALF_SPAN);
            white_xy[i] = cell_at(white_plane, int'(consider_y) + i - HALF_SPAN,
                                  int'(consider_x) - i + HALF_SPAN);
        end
    end

    // Clear beats write; a write lands only on an empty on-board cell, otherwise it is refused.
    always_ff @(posedge clk_slow or negedge rst) begin
        if (!rst) begin
            black_plane  <= '0;
            white_plane  <= '0;
            move_count   <= '0;
            last_y       <= NO_COORD;
            last_x       <= NO_COORD;
            write_ack    <= 1'b0;
            write_reject <= 1'b0;
        end else begin
            write_ack    <= 1'b0;
            write_reject <= 1'b0;
            if (data_clr) begin
                black_plane <= '0;
                white_plane <= '0;
                move_count  <= '0;
                last_y      <= NO_COORD;
                last_x      <= NO_COORD;
            end else if (data_write) begin
                if (cursor_in_range && !cursor_occupied) begin
                    if (crt_player)
                        white_plane[cursor_y][cursor_x] <= 1'b1;
                    else
                        black_plane[cursor_y][cursor_x] <= 1'b1;
                    if (move_count != CELL_COUNT)
                        move_count <= move_count + 8'd1;
                    last_y    <= cursor_y;
                    last_x    <= cursor_x;
                    write_ack <= 1'b1;
                end else begin
                    write_reject <= 1'b1;
                end
            end
        end
    end

    assign board_full = (move_count == CELL_COUNT);

endmodule

// File: tb/tb_gomoku_board_store.sv
// Directed bench for gomoku_board_store: expectations are queued as each step is
// driven and popped against the DUT outputs one cycle-phase later.
module tb_gomoku_board_store;

    logic        clk_slow;
    logic        rst;
    logic        data_clr;
    logic        data_write;
    logic [3:0]  cursor_y;
    logic [3:0]  cursor_x;
    logic        crt_player;
    logic [3:0]  consider_y;
    logic [3:0]  consider_x;
    logic [8:0]  black_y, black_x, black_yx, black_xy;
    logic [8:0]  white_y, white_x, white_yx, white_xy;
    logic [14:0] chess_row;
    logic [7:0]  move_count;
    logic [3:0]  last_y;
    logic [3:0]  last_x;
    logic        write_ack;
    logic        write_reject;
    logic        board_full;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } expect_t;

    expect_t sb[$];
    int      errors = 0;
    int      checks = 0;

    gomoku_board_store dut (
        .clk_slow     (clk_slow),
        .rst          (rst),
        .data_clr     (data_clr),
        .data_write   (data_write),
        .cursor_y     (cursor_y),
        .cursor_x     (cursor_x),
        .crt_player   (crt_player),
        .consider_y   (consider_y),
        .consider_x   (consider_x),
        .black_y      (black_y),
        .black_x      (black_x),
        .black_yx     (black_yx),
        .black_xy     (black_xy),
        .white_y      (white_y),
        .white_x      (white_x),
        .white_yx     (white_yx),
        .white_xy     (white_xy),
        .chess_row    (chess_row),
        .move_count   (move_count),
        .last_y       (last_y),
        .last_x       (last_x),
        .write_ack    (write_ack),
        .write_reject (write_reject),
        .board_full   (board_full)
    );

    initial clk_slow = 1'b0;
    always #5 clk_slow = ~clk_slow;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic push_expect(input string tag, input logic [31:0] value);
        sb.push_back('{tag, value});
    endtask

    task automatic check_output(input logic [31:0] observed);
        expect_t item;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_empty: observed=%0h expected=none", observed);
        end else begin
            item = sb.pop_front();
            assert (observed === item.value)
            else begin
                errors++;
                $error("[TB] FAIL %s: observed=%0h expected=%0h", item.tag, observed, item.value);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_slow);
        #1;
    endtask

    task automatic write_cell(input logic [3:0] y, input logic [3:0] x, input logic p);
        cursor_y   = y;
        cursor_x   = x;
        crt_player = p;
        data_write = 1'b1;
        tick();
        data_write = 1'b0;
    endtask

    task automatic set_consider(input logic [3:0] y, input logic [3:0] x);
        consider_y = y;
        consider_x = x;
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        data_clr   = 1'b0;
        data_write = 1'b0;
        cursor_y   = 4'd7;
        cursor_x   = 4'd7;
        crt_player = 1'b0;
        consider_y = 4'd7;
        consider_x = 4'd7;

        // Reset state, observed while reset is still held.
        #12;
        push_expect("rst_move_count", 0);     check_output(move_count);
        push_expect("rst_last_y", 15);        check_output(last_y);
        push_expect("rst_last_x", 15);        check_output(last_x);
        push_expect("rst_ack", 0);            check_output(write_ack);
        push_expect("rst_reject", 0);         check_output(write_reject);
        push_expect("rst_full", 0);           check_output(board_full);
        push_expect("rst_chess_row", 0);      check_output(chess_row);
        #1 rst = 1'b1;

        // First black stone at the centre.
        push_expect("w77_ack", 1);
        push_expect("w77_reject", 0);
        push_expect("w77_chess_row", 15'h0080);
        push_expect("w77_move_count", 1);
        push_expect("w77_last_y", 7);
        push_expect("w77_last_x", 7);
        push_expect("w77_black_x", 9'h010);
        push_expect("w77_white_x", 9'h000);
        write_cell(4'd7, 4'd7, 1'b0);
        check_output(write_ack);
        check_output(write_reject);
        check_output(chess_row);
        check_output(move_count);
        check_output(last_y);
        check_output(last_x);
        check_output(black_x);
        check_output(white_x);
        push_expect("w77_ack_drop", 0);
        tick();
        check_output(write_ack);

        // White onto the occupied centre is refused and changes nothing.
        push_expect("dup_reject", 1);
        push_expect("dup_ack", 0);
        push_expect("dup_move_count", 1);
        push_expect("dup_black_x", 9'h010);
        push_expect("dup_white_x", 9'h000);
        write_cell(4'd7, 4'd7, 1'b1);
        check_output(write_reject);
        check_output(write_ack);
        check_output(move_count);
        check_output(black_x);
        check_output(white_x);
        push_expect("dup_reject_drop", 0);
        tick();
        check_output(write_reject);

        // Black stones along row 0, columns 0..4.
        for (int c = 0; c < 5; c++) begin
            push_expect("row0_ack", 1);
            write_cell(4'd0, 4'(c), 1'b0);
            check_output(write_ack);
        end
        push_expect("row0_move_count", 6);    check_output(move_count);

        set_consider(4'd0, 4'd2);
        push_expect("c02_black_x", 9'b001111100);  check_output(black_x);
        push_expect("c02_black_y", 9'b000010000);  check_output(black_y);
        push_expect("c02_white_any", 0);
        check_output(white_x | white_y | white_yx | white_xy);

        set_consider(4'd0, 4'd0);
        push_expect("c00_black_yx", 9'b000010000); check_output(black_yx);
        push_expect("c00_black_xy", 9'b000010000); check_output(black_xy);
        push_expect("c00_black_x", 9'b111110000);  check_output(black_x);

        set_consider(4'd3, 4'd3);
        push_expect("c33_black_yx", 9'b100000010); check_output(black_yx);
        push_expect("c33_black_xy", 9'b000000000); check_output(black_xy);

        set_consider(4'd4, 4'd0);
        push_expect("c40_black_xy", 9'b000000001); check_output(black_xy);
        push_expect("c40_black_y", 9'b000000001);  check_output(black_y);

        set_consider(4'd15, 4'd15);
        push_expect("cff_all", 0);
        check_output(black_y | black_x | black_yx | black_xy |
                     white_y | white_x | white_yx | white_xy);

        // Off-board cursor write is refused; chess_row is blank for row 15.
        push_expect("oob_reject", 1);
        push_expect("oob_move_count", 6);
        push_expect("oob_chess_row", 0);
        write_cell(4'd15, 4'd3, 1'b0);
        check_output(write_reject);
        check_output(move_count);
        check_output(chess_row);
        cursor_y = 4'd0;
        cursor_x = 4'd0;
        #1;
        push_expect("row0_chess_row", 15'h001F);   check_output(chess_row);

        // Clear wins over a simultaneous write.
        data_clr   = 1'b1;
        data_write = 1'b1;
        cursor_y   = 4'd10;
        cursor_x   = 4'd10;
        set_consider(4'd0, 4'd2);
        push_expect("clr_ack", 0);
        push_expect("clr_reject", 0);
        push_expect("clr_move_count", 0);
        push_expect("clr_last_y", 15);
        push_expect("clr_last_x", 15);
        push_expect("clr_black_x", 0);
        push_expect("clr_chess_row", 0);
        tick();
        data_clr   = 1'b0;
        data_write = 1'b0;
        check_output(write_ack);
        check_output(write_reject);
        check_output(move_count);
        check_output(last_y);
        check_output(last_x);
        check_output(black_x);
        check_output(chess_row);

        // Fill the board, colour alternating by linear cell index.
        for (int y = 0; y < 15; y++) begin
            for (int x = 0; x < 15; x++) begin
                push_expect("fill_ack", 1);
                write_cell(4'(y), 4'(x), 1'((y * 15 + x) % 2));
                check_output(write_ack);
            end
        end
        set_consider(4'd7, 4'd7);
        push_expect("fill_full", 1);           check_output(board_full);
        push_expect("fill_move_count", 225);   check_output(move_count);
        push_expect("fill_last_y", 14);        check_output(last_y);
        push_expect("fill_last_x", 14);        check_output(last_x);
        push_expect("fill_white_x", 9'h0AA);   check_output(white_x);
        push_expect("fill_black_x", 9'h155);   check_output(black_x);

        push_expect("full_reject", 1);
        push_expect("full_move_count", 225);
        write_cell(4'd7, 4'd7, 1'b0);
        check_output(write_reject);
        check_output(move_count);

        // Asynchronous reset between clock edges.
        cursor_y = 4'd7;
        #2 rst = 1'b0;
        #1;
        push_expect("arst_move_count", 0);    check_output(move_count);
        push_expect("arst_last_y", 15);       check_output(last_y);
        push_expect("arst_last_x", 15);       check_output(last_x);
        push_expect("arst_reject", 0);        check_output(write_reject);
        push_expect("arst_ack", 0);           check_output(write_ack);
        push_expect("arst_full", 0);          check_output(board_full);
        push_expect("arst_windows", 0);
        check_output(black_y | black_x | black_yx | black_xy |
                     white_y | white_x | white_yx | white_xy);
        push_expect("arst_chess_row", 0);     check_output(chess_row);

        push_expect("sb_drained", 0);
        check_output(32'(sb.size() - 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
